prefix_adder_arbiter: RTL and testbench
=======================================

Name: prefix_adder_arbiter

Overview:
- Shares one 8-bit pipelined prefix adder between two requesters of the floating point multiplier (exponent add and mantissa rounding).
- Grants at most one operation per cycle, round-robin, using a valid/ready handshake.
- Drives the adder operands and tracks in-flight operations with a valid/tag shift register.
- Routes each SUM/cout back to the requester that issued it.

Parameters:
- WIDTH, 8, operand/sum width; must match the adder instance.
- LATENCY, 2, rising edges from the issue cycle to the cycle the result is valid on add_sum/add_cout (two internal register stages); must be >= 1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- stall  in  1  when high, no new grants this cycle; in-flight ops continue
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_x, req0_y  in  WIDTH  requester 0 operands
- req0_cin  in  1  requester 0 carry-in
- req1_valid, req1_ready, req1_x, req1_y, req1_cin  as requester 0
- add_x, add_y  out  WIDTH  operands to adder X, Y
- add_cin  out  1  to adder cin
- add_sum  in  WIDTH  adder SUM
- add_cout  in  1  adder cout
- rsp0_valid  out  1  one-cycle pulse: result for requester 0
- rsp0_sum  out  WIDTH  requester 0 result sum
- rsp0_cout  out  1  requester 0 result carry-out
- rsp1_valid, rsp1_sum, rsp1_cout  as rsp0
- busy  out  1  any operation in flight or any rsp_valid high

Behaviour:
- Reset (async, immediate):
  - prio=0; in-flight vld[LATENCY-1:0]=0; tags=0.
  - rsp*_valid=0, rsp*_sum=0, rsp*_cout=0; busy=0.
- Reset mid-operation:
  - All in-flight ops are dropped; no response is ever emitted for them.
  - Adder internal state is ignored because it carries no tag.
- Arbitration (combinational, same cycle):
  - grant0 = !stall & req0_valid & (!req1_valid | prio==0).
  - grant1 = !stall & req1_valid & (!req0_valid | prio==1).
  - At most one grant per cycle. reqN_ready = grantN.
- Issue: a grant is a handshake (valid & ready).
  - add_x/add_y/add_cin = granted requester's operands, combinational.
  - All zeros when there is no grant.
- Priority update on every issue: prio <= ~granted_id. This also applies when only one requester was valid. No update on idle or stall cycles.
- Requester rule: hold valid and operands stable until ready. A request may be withdrawn before it is granted; the arbiter takes no action on withdrawal.
- Tracking pipeline, at each edge:
  - vld[0] <= issue; tag[0] <= granted_id.
  - vld[i] <= vld[i-1]; tag[i] <= tag[i-1].
- Response capture:
  - Each cycle with vld[LATENCY-1]=1, the next edge loads add_sum/add_cout into rsp<tag>_sum/cout and pulses rsp<tag>_valid for one cycle.
  - The other requester's rsp_valid is 0.
- Response data holds its last value between pulses.
- Issue-to-response latency is exactly LATENCY+1 edges (3 with the default).
- No response backpressure: the adder cannot stall, so requesters must accept every rsp_valid pulse.
- Throughput: one op per cycle sustained. Back-to-back issues produce back-to-back rsp pulses in issue order.
- Simultaneous events:
  - Issue and response in the same cycle are independent.
  - stall does not affect the tracking pipeline or responses.
- busy = |vld | rsp0_valid | rsp1_valid.
- Widths: all arithmetic is done by the adder. The arbiter only muxes and registers; no truncation or extension.

Test Plan:
- Reset, then only req0 issues x=0x3C, y=0x05, cin=0 at cycle 0 -> req0_ready=1 at cycle 0; rsp0_valid pulses at cycle 3 with sum=0x41, cout=0; rsp1_valid stays 0.
- Both requesters valid for 4 cycles from reset (prio=0), req0 {0xFF+0x01, cin0}, req1 {0x80+0x80, cin1} -> grants alternate 0,1,0,1. Responses at cycles 3,4,5,6: rsp0 sum=0x00 cout=1; rsp1 sum=0x01 cout=1.
- Only req1 valid for 2 cycles, then both valid -> the third grant goes to req0 (prio flipped to 0 by the req1 issues).
- stall=1 with both valid -> no ready, add_x=add_y=0, no rsp three cycles later. In-flight ops issued before the stall still respond on time.
- Issue two ops, assert rst one cycle after the second issue -> outputs 0 immediately; no rsp pulses; busy=0 after release.
- Random back-to-back traffic for 1000 cycles -> every response matches the scoreboard (x+y+cin), arrives in order with correct tag at issue+3, and busy is consistent.

Source files
------------

// File: rtl/prefix_adder_arbiter.sv
// Round-robin arbiter sharing one pipelined prefix adder between two requesters.
// Operands are muxed combinationally on a grant. A valid/tag shift register follows
// each operation through the adder so that its result goes back to the requester
// that issued it.
module prefix_adder_arbiter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  // Requester 0
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  input  logic             req0_cin,
  // Requester 1
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  input  logic             req1_cin,
  // Shared adder
  output logic [WIDTH-1:0] add_x,
  output logic [WIDTH-1:0] add_y,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  // Responses
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_sum,
  output logic             rsp0_cout,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_sum,
  output logic             rsp1_cout,
  output logic             busy
);

  logic               prio_q;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [LATENCY-1:0] tag_q, tag_d;

  logic grant0, grant1, issue, grant_id;

  logic             rsp0_valid_q, rsp1_valid_q;
  logic [WIDTH-1:0] rsp0_sum_q, rsp1_sum_q;
  logic             rsp0_cout_q, rsp1_cout_q;

  // Round-robin grant: prio only matters when both requesters are valid.
  always_comb begin
    grant0   = ~stall & req0_valid & (~req1_valid | ~prio_q);
    grant1   = ~stall & req1_valid & (~req0_valid | prio_q);
    issue    = grant0 | grant1;
    grant_id = grant1;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Drive the adder with the granted operands, zeros when idle.
  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_cin = 1'b0;
    if (grant0) begin
      add_x   = req0_x;
      add_y   = req0_y;
      add_cin = req0_cin;
    end else if (grant1) begin
      add_x   = req1_x;
      add_y   = req1_y;
      add_cin = req1_cin;
    end
  end

  // Tracking pipeline next state: entry 0 takes the current issue.
  always_comb begin
    vld_d    = '0;
    tag_d    = '0;
    vld_d[0] = issue;
    tag_d[0] = grant_id;
    for (int i = 1; i < int'(LATENCY); i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
  end

  // Priority and tracking state; priority flips away from whoever was just served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= 1'b0;
      vld_q  <= '0;
      tag_q  <= '0;
    end else begin
      if (issue) begin
        prio_q <= ~grant_id;
      end
      vld_q <= vld_d;
      tag_q <= tag_d;
    end
  end

  // Capture the adder result into the tagged requester's response; data holds between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_sum_q   <= '0;
      rsp1_sum_q   <= '0;
      rsp0_cout_q  <= 1'b0;
      rsp1_cout_q  <= 1'b0;
    end else begin
      rsp0_valid_q <= vld_q[LATENCY-1] & ~tag_q[LATENCY-1];
      rsp1_valid_q <= vld_q[LATENCY-1] & tag_q[LATENCY-1];
      if (vld_q[LATENCY-1] & ~tag_q[LATENCY-1]) begin
        rsp0_sum_q  <= add_sum;
        rsp0_cout_q <= add_cout;
      end
      if (vld_q[LATENCY-1] & tag_q[LATENCY-1]) begin
        rsp1_sum_q  <= add_sum;
        rsp1_cout_q <= add_cout;
      end
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp0_sum   = rsp0_sum_q;
  assign rsp0_cout  = rsp0_cout_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp1_sum   = rsp1_sum_q;
  assign rsp1_cout  = rsp1_cout_q;

  assign busy = (|vld_q) | rsp0_valid_q | rsp1_valid_q;

endmodule

// File: tb/tb_prefix_adder_arbiter.sv
// Bench for prefix_adder_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based model. A two-stage pipelined adder model sits on the adder port.
module tb_prefix_adder_arbiter;

  logic       clk, rst, stall;
  logic       req0_valid, req0_ready, req0_cin;
  logic [7:0] req0_x, req0_y;
  logic       req1_valid, req1_ready, req1_cin;
  logic [7:0] req1_x, req1_y;
  logic [7:0] add_x, add_y, add_sum;
  logic       add_cin, add_cout;
  logic       rsp0_valid, rsp0_cout, rsp1_valid, rsp1_cout, busy;
  logic [7:0] rsp0_sum, rsp1_sum;

  int errors = 0;
  int checks = 0;

  prefix_adder_arbiter #(.WIDTH(8), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
    .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
    .req1_cin(req1_cin),
    .add_x(add_x), .add_y(add_y), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .rsp0_valid(rsp0_valid), .rsp0_sum(rsp0_sum), .rsp0_cout(rsp0_cout),
    .rsp1_valid(rsp1_valid), .rsp1_sum(rsp1_sum), .rsp1_cout(rsp1_cout),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-register pipelined adder: result appears two edges after the operands.
  logic [8:0] pa1 = '0, pa2 = '0;
  always @(posedge clk) begin
    pa1 <= {1'b0, add_x} + {1'b0, add_y} + {8'd0, add_cin};
    pa2 <= pa1;
  end
  assign add_sum  = pa2[7:0];
  assign add_cout = pa2[8];

  task automatic drive(input logic v0, input logic [7:0] x0, input logic [7:0] y0,
                       input logic c0, input logic v1, input logic [7:0] x1,
                       input logic [7:0] y1, input logic c1, input logic st);
    req0_valid = v0; req0_x = x0; req0_y = y0; req0_cin = c0;
    req1_valid = v1; req1_x = x1; req1_y = y1; req1_cin = c1;
    stall = st;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin errors++;
      $display("FAIL reset_rsp_valid got %b%b want 00", rsp0_valid, rsp1_valid); end
    checks++; if (rsp0_sum !== 8'h00 || rsp1_sum !== 8'h00) begin errors++;
      $display("FAIL reset_rsp_sum got %0h/%0h want 0/0", rsp0_sum, rsp1_sum); end
    checks++; if (rsp0_cout !== 1'b0 || rsp1_cout !== 1'b0) begin errors++;
      $display("FAIL reset_rsp_cout got %b%b want 00", rsp0_cout, rsp1_cout); end
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL reset_busy got %b want 0", busy); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      if (c == 0) drive(1, 8'h3C, 8'h05, 0, 0, 0, 0, 0, 0);
      else        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      if (c == 0) begin
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++;
          $display("FAIL single_ready got %b%b want 10", req0_ready, req1_ready); end
        checks++; if (add_x !== 8'h3C || add_y !== 8'h05 || add_cin !== 1'b0) begin errors++;
          $display("FAIL single_operands got %0h %0h %b want 3c 5 0", add_x, add_y, add_cin); end
      end
      checks++; if (rsp0_valid !== (c == 3) || rsp1_valid !== 1'b0) begin errors++;
        $display("FAIL single_rsp_valid c=%0d got %b%b want %b0", c, rsp0_valid, rsp1_valid,
                 c == 3); end
      if (c >= 3) begin
        checks++; if (rsp0_sum !== 8'h41 || rsp0_cout !== 1'b0) begin errors++;
          $display("FAIL single_rsp_data c=%0d got %0h/%b want 41/0", c, rsp0_sum, rsp0_cout); end
      end
      checks++; if (busy !== (c >= 1 && c <= 3)) begin errors++;
        $display("FAIL single_busy c=%0d got %b want %b", c, busy, c >= 1 && c <= 3); end
      tick();
    end
  endtask

  task automatic test_alternate();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      if (c < 4) drive(1, 8'hFF, 8'h01, 0, 1, 8'h80, 8'h80, 1, 0);
      else       drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (req0_ready !== (c < 4 && c % 2 == 0) || req1_ready !== (c < 4 && c % 2 == 1)) begin
        errors++;
        $display("FAIL alt_ready c=%0d got %b%b", c, req0_ready, req1_ready);
      end
      if (c < 4) begin
        checks++; if (add_x !== ((c % 2 == 0) ? 8'hFF : 8'h80)) begin errors++;
          $display("FAIL alt_add_x c=%0d got %0h", c, add_x); end
      end
      checks++;
      if (rsp0_valid !== (c == 3 || c == 5) || rsp1_valid !== (c == 4 || c == 6)) begin
        errors++;
        $display("FAIL alt_rsp_valid c=%0d got %b%b", c, rsp0_valid, rsp1_valid);
      end
      if (c == 3 || c == 5) begin
        checks++; if (rsp0_sum !== 8'h00 || rsp0_cout !== 1'b1) begin errors++;
          $display("FAIL alt_rsp0 c=%0d got %0h/%b want 0/1", c, rsp0_sum, rsp0_cout); end
      end
      if (c == 4 || c == 6) begin
        checks++; if (rsp1_sum !== 8'h01 || rsp1_cout !== 1'b1) begin errors++;
          $display("FAIL alt_rsp1 c=%0d got %0h/%b want 1/1", c, rsp1_sum, rsp1_cout); end
      end
      tick();
    end
  endtask

  task automatic test_prio_flip();
    do_reset();
    for (int c = 0; c < 7; c++) begin
      if (c < 2)       drive(0, 0, 0, 0, 1, 8'h11, 8'h22, 0, 0);
      else if (c == 2) drive(1, 8'h01, 8'h01, 0, 1, 8'h11, 8'h22, 0, 0);
      else             drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      if (c < 2) begin
        checks++; if (req1_ready !== 1'b1) begin errors++;
          $display("FAIL prio_req1_only c=%0d got %b want 1", c, req1_ready); end
      end
      if (c == 2) begin
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++;
          $display("FAIL prio_third_grant got %b%b want 10", req0_ready, req1_ready); end
      end
      if (c == 5) begin
        checks++; if (rsp0_valid !== 1'b1 || rsp0_sum !== 8'h02) begin errors++;
          $display("FAIL prio_rsp0 got %b/%0h want 1/2", rsp0_valid, rsp0_sum); end
      end
      if (c == 3) begin
        checks++; if (rsp1_valid !== 1'b1 || rsp1_sum !== 8'h33) begin errors++;
          $display("FAIL prio_rsp1 got %b/%0h want 1/33", rsp1_valid, rsp1_sum); end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      if (c == 0)      drive(1, 8'h10, 8'h20, 0, 0, 0, 0, 0, 0);
      else if (c <= 2) drive(1, 8'h55, 8'h66, 1, 1, 8'h77, 8'h88, 1, 1);
      else             drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      if (c == 1 || c == 2) begin
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++;
          $display("FAIL stall_ready c=%0d got %b%b want 00", c, req0_ready, req1_ready); end
        checks++; if (add_x !== 8'h00 || add_y !== 8'h00 || add_cin !== 1'b0) begin errors++;
          $display("FAIL stall_operands c=%0d got %0h %0h %b", c, add_x, add_y, add_cin); end
      end
      checks++; if (rsp0_valid !== (c == 3) || rsp1_valid !== 1'b0) begin errors++;
        $display("FAIL stall_rsp_valid c=%0d got %b%b want %b0", c, rsp0_valid, rsp1_valid,
                 c == 3); end
      if (c == 3) begin
        checks++; if (rsp0_sum !== 8'h30) begin errors++;
          $display("FAIL stall_inflight_sum got %0h want 30", rsp0_sum); end
      end
      if (c >= 4) begin
        checks++; if (busy !== 1'b0) begin errors++;
          $display("FAIL stall_busy c=%0d got %b want 0", c, busy); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1, 8'h01, 8'h02, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 8'h03, 8'h04, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin errors++;
      $display("FAIL midrst_immediate got busy=%b rsp=%b%b want 0 00", busy, rsp0_valid,
               rsp1_valid); end
    checks++; if (rsp0_sum !== 8'h00 || rsp1_sum !== 8'h00) begin errors++;
      $display("FAIL midrst_sums got %0h/%0h want 0/0", rsp0_sum, rsp1_sum); end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midrst_after c=%0d got rsp=%b%b busy=%b want 00 0", c, rsp0_valid,
                 rsp1_valid, busy);
      end
      tick();
    end
  endtask

  typedef struct {
    bit         id;
    logic [8:0] res;
    int         due;
  } rsp_t;

  task automatic test_random();
    rsp_t       q[$];
    bit         prio_m = 0;
    logic [8:0] last0 = '0, last1 = '0;
    logic       v0 = 0, v1 = 0, c0 = 0, c1 = 0, st;
    logic [7:0] x0 = 0, y0 = 0, x1 = 0, y1 = 0;
    logic       g0, g1, e0, e1, eb;
    logic [7:0] ex, ey;
    logic       ec;
    do_reset();
    for (int cyc = 0; cyc < 1000; cyc++) begin
      // A pending request holds its operands until granted.
      if (!v0) begin v0 = ($urandom_range(0, 3) != 0); x0 = 8'($urandom);
        y0 = 8'($urandom); c0 = 1'($urandom); end
      if (!v1) begin v1 = ($urandom_range(0, 3) != 0); x1 = 8'($urandom);
        y1 = 8'($urandom); c1 = 1'($urandom); end
      st = ($urandom_range(0, 7) == 0);
      drive(v0, x0, y0, c0, v1, x1, y1, c1, st);
      g0 = !st && v0 && (!v1 || prio_m == 0);
      g1 = !st && v1 && !g0;
      checks++; if (req0_ready !== g0 || req1_ready !== g1) begin errors++;
        $display("FAIL rand_ready cyc=%0d got %b%b want %b%b", cyc, req0_ready, req1_ready,
                 g0, g1); end
      ex = g0 ? x0 : (g1 ? x1 : 8'h00);
      ey = g0 ? y0 : (g1 ? y1 : 8'h00);
      ec = g0 ? c0 : (g1 ? c1 : 1'b0);
      checks++; if (add_x !== ex || add_y !== ey || add_cin !== ec) begin errors++;
        $display("FAIL rand_operands cyc=%0d got %0h %0h %b want %0h %0h %b", cyc, add_x,
                 add_y, add_cin, ex, ey, ec); end
      eb = (q.size() > 0);
      e0 = 0; e1 = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
        if (q[0].id) begin e1 = 1; last1 = q[0].res; end
        else         begin e0 = 1; last0 = q[0].res; end
        void'(q.pop_front());
      end
      checks++; if (rsp0_valid !== e0 || rsp1_valid !== e1) begin errors++;
        $display("FAIL rand_rsp_valid cyc=%0d got %b%b want %b%b", cyc, rsp0_valid,
                 rsp1_valid, e0, e1); end
      checks++; if ({rsp0_cout, rsp0_sum} !== last0 || {rsp1_cout, rsp1_sum} !== last1) begin
        errors++;
        $display("FAIL rand_rsp_data cyc=%0d got %0h/%0h want %0h/%0h", cyc,
                 {rsp0_cout, rsp0_sum}, {rsp1_cout, rsp1_sum}, last0, last1);
      end
      checks++; if (busy !== eb) begin errors++;
        $display("FAIL rand_busy cyc=%0d got %b want %b", cyc, busy, eb); end
      if (g0 || g1) begin
        q.push_back('{id: g1, res: {1'b0, ex} + {1'b0, ey} + {8'd0, ec}, due: cyc + 3});
        prio_m = !g1;
      end
      if (g0) v0 = 0;
      if (g1) v1 = 0;
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_prio_flip();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
